ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
Instruction fetch stage, directly upstream of the decoder. Holds the architectural fetch PC and requests one 32-bit instruction at a time from the instruction cache. It presents the instruction, its PC and a branch prediction to the decoder, then advances to the decoder-computed next PC. A 2-bit-counter branch history table (BHT), trained by the RoB at commit, supplies the prediction. A RoB flush redirects the fetch PC on misprediction.

Parameters:
RESET_PC, 32'h0, fetch PC after reset.
BHT_BITS, 6, log2 of BHT entries (64); index = pc[BHT_BITS+1:2].

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; when low, all state holds
ic_req  output 1  fetch request; held high until ic_valid
ic_addr output 32 fetch address; stable while ic_req high
ic_valid input 1  one-cycle pulse; ic_instr valid
ic_instr input 32 fetched instruction
if_valid output 1  instr/pc/isjump valid to decoder
instr   output 32 instruction to decoder
pc      output 32 PC of instr
isjump  output 1  predicted taken (conditional branches only)
dc_valid input 1  decoder accepted current instruction this cycle
dc_nextpc input 32 next fetch PC computed by decoder
rob_flush input 1  misprediction redirect
rob_flush_pc input 32 redirect target
rob_br_valid input 1  committed conditional branch outcome valid
rob_br_pc input 32 PC of committed branch
rob_br_taken input 1  actual outcome

Behaviour:
- Reset (rst_in=1, takes priority over rdy_in):
  - fetch PC = RESET_PC; state = IDLE.
  - ic_req, ic_addr, if_valid, instr, pc, isjump = 0.
  - All BHT entries = 2'b01 (weakly not taken).
- rdy_in=0: no state, output or BHT change; inputs ignored.
- FSM states:
  - IDLE: ic_req<=1, ic_addr<=fetch PC; go to WAIT.
  - WAIT: on ic_valid: instr<=ic_instr, pc<=ic_addr, if_valid<=1, ic_req<=0; go to HOLD.
    - isjump<=1 only if ic_instr[6:0]==7'b1100011 and the BHT counter at ic_addr has bit[1]=1.
  - HOLD: outputs stable. On dc_valid: if_valid<=0, fetch PC<=dc_nextpc; go to IDLE.
  - DISCARD: ic_req stays high with the old ic_addr. On ic_valid: the response is dropped, ic_req<=0; go to IDLE.
- Latency:
  - Request issues 1 cycle after entering IDLE.
  - if_valid rises the cycle after ic_valid.
  - Next request issues 2 cycles after dc_valid.
  - if_valid deasserts the cycle after dc_valid, so the decoder never sees the same instruction twice.
- Flush (rob_flush=1) overrides all other events in the same cycle; fetch PC<=rob_flush_pc, if_valid<=0.
  - IDLE or HOLD: go to IDLE. dc_valid in the same cycle is ignored.
  - WAIT without ic_valid: go to DISCARD (request outstanding).
  - WAIT with ic_valid: response dropped, ic_req<=0; go to IDLE.
  - DISCARD: stay in DISCARD with the updated PC.
- ic_valid in IDLE or HOLD is ignored. dc_valid outside HOLD is ignored.
- BHT update (rob_br_valid=1, independent of FSM and flush):
  - Entry at rob_br_pc: taken increments, saturating at 3; not taken decrements, saturating at 0.
  - If lookup and update hit the same index in the same cycle, the lookup uses the pre-update value.
- All PC arithmetic is 32-bit modulo.

Test Plan:
- Reset, then icache returns 32'h00000013 two cycles after each req:
  - ic_addr sequence 0, 4, 8.
  - if_valid pulses with pc=0, 4, 8; isjump=0.
  - Decoder accepts immediately with dc_nextpc=pc+4.
- BHT training: three rob_br_valid/taken commits at pc 0x10 (01→10→11→11), then fetch of beq at 0x10 → isjump=1. Two not-taken commits (11→10→01), refetch → isjump=0.
- Flush in WAIT at 0x20 with no ic_valid, rob_flush_pc=0x100:
  - Next ic_valid is dropped (if_valid stays 0).
  - Next ic_addr=0x100.
- rob_flush=1 and dc_valid=1 in the same cycle in HOLD (dc_nextpc=0x44, rob_flush_pc=0x200) → next ic_addr=0x200.
- rdy_in=0 for 5 cycles mid-WAIT (ic_valid pulse while rdy_in=0) → no state or output change. After rdy_in returns, FSM resumes in WAIT.
- rst_in asserted in HOLD → next cycle if_valid=0, ic_req=0. Then ic_addr=RESET_PC, and BHT reads back 01 (isjump=0 for a branch).

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the fetch PC, runs the icache request handshake,
// and presents instr/pc/branch prediction to the decoder from a 2-bit-counter BHT.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BHT_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_instr,
  output logic        if_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        isjump,
  input  logic        dc_valid,
  input  logic [31:0] dc_nextpc,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc,
  input  logic        rob_br_valid,
  input  logic [31:0] rob_br_pc,
  input  logic        rob_br_taken,
  output logic [1:0]  dbg_state_o
);

  localparam int BHT_N = 1 << BHT_BITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        ic_req_q, ic_req_d;
  logic [31:0] ic_addr_q, ic_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        isjump_q, isjump_d;
  logic [1:0]  bht_q [BHT_N];

  logic [BHT_BITS-1:0] lkp_idx;
  logic [BHT_BITS-1:0] upd_idx;
  logic                is_branch;
  logic                unused_bits;

  assign lkp_idx     = ic_addr_q[BHT_BITS+1:2];
  assign upd_idx     = rob_br_pc[BHT_BITS+1:2];
  assign is_branch   = (ic_instr[6:0] == 7'b1100011);
  assign unused_bits = ^{rob_br_pc[31:BHT_BITS+2], rob_br_pc[1:0]};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      ic_req_q   <= 1'b0;
      ic_addr_q  <= 32'h0;
      if_valid_q <= 1'b0;
      instr_q    <= 32'h0;
      pc_q       <= 32'h0;
      isjump_q   <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ic_req_q   <= ic_req_d;
      ic_addr_q  <= ic_addr_d;
      if_valid_q <= if_valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      isjump_q   <= isjump_d;
    end
  end

  // Lookup reads bht_q combinationally, so a same-cycle update is not seen.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (rdy_in && rob_br_valid) begin
      if (rob_br_taken && (bht_q[upd_idx] != 2'b11))
        bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      else if (!rob_br_taken && (bht_q[upd_idx] != 2'b00))
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ic_req_d   = ic_req_q;
    ic_addr_d  = ic_addr_q;
    if_valid_d = if_valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    isjump_d   = isjump_q;
    if (rob_flush) begin
      fetch_pc_d = rob_flush_pc;
      if_valid_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (!rob_flush) begin
          ic_req_d  = 1'b1;
          ic_addr_d = fetch_pc_q;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rob_flush) begin
          if (ic_valid) begin
            ic_req_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_DISCARD;
          end
        end else if (ic_valid) begin
          instr_d    = ic_instr;
          pc_d       = ic_addr_q;
          isjump_d   = is_branch && bht_q[lkp_idx][1];
          if_valid_d = 1'b1;
          ic_req_d   = 1'b0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rob_flush) begin
          state_d = S_IDLE;
        end else if (dc_valid) begin
          if_valid_d = 1'b0;
          fetch_pc_d = dc_nextpc;
          state_d    = S_IDLE;
        end
      end
      S_DISCARD: begin
        // The stale response retires the outstanding request even under a flush.
        if (ic_valid) begin
          ic_req_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ic_req      = ic_req_q;
  assign ic_addr     = ic_addr_q;
  assign if_valid    = if_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign isjump      = isjump_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: icache/decoder/RoB driver tasks, a scoreboard queue of
// expected {pc, instr, isjump} per decoder-visible instruction, and a final report.
module tb_ifetch;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_instr;
  logic        if_valid;
  logic [31:0] instr, pc;
  logic        isjump;
  logic        dc_valid;
  logic [31:0] dc_nextpc;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;
  logic        rob_br_valid;
  logic [31:0] rob_br_pc;
  logic        rob_br_taken;
  logic [1:0]  dbg_state_o;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BEQ = 32'h00000063;
  localparam logic [1:0]  ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DISCARD = 2'd3;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];
  logic [64:0] got, want;
  logic        prev_v = 1'b0;

  always #5 clk_in = ~clk_in;

  ifetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_instr(ic_instr),
    .if_valid(if_valid), .instr(instr), .pc(pc), .isjump(isjump),
    .dc_valid(dc_valid), .dc_nextpc(dc_nextpc),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc),
    .rob_br_valid(rob_br_valid), .rob_br_pc(rob_br_pc), .rob_br_taken(rob_br_taken),
    .dbg_state_o(dbg_state_o)
  );

  // Scoreboard: each rising if_valid must match the oldest expected entry.
  always @(negedge clk_in) begin
    if (if_valid === 1'b1 && prev_v !== 1'b1) begin
      checks++;
      got = {pc, instr, isjump};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h instr=%h isjump=%0b want no instruction", pc, instr, isjump);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL sb_fetch got pc=%h instr=%h isjump=%0b want pc=%h instr=%h isjump=%0b",
                   got[64:33], got[32:1], got[0], want[64:33], want[32:1], want[0]);
        end
      end
    end
    prev_v = if_valid;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (ic_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ic_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout got ic_req=%0b want 1", ic_req);
    end
  endtask

  task automatic respond(input logic [31:0] ins, input logic push,
                         input logic [31:0] exp_pc, input logic exp_jump);
    if (push) exp_q.push_back({exp_pc, ins, exp_jump});
    ic_valid = 1'b1;
    ic_instr = ins;
    tick();
    ic_valid = 1'b0;
  endtask

  task automatic accept(input logic [31:0] np);
    dc_valid  = 1'b1;
    dc_nextpc = np;
    tick();
    dc_valid  = 1'b0;
  endtask

  task automatic train(input logic [31:0] p, input logic t, input int n);
    rob_br_valid = 1'b1;
    rob_br_pc    = p;
    rob_br_taken = t;
    repeat (n) tick();
    rob_br_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] ins,
                       input logic exp_jump, input logic [31:0] np);
    wait_req();
    tick();
    respond(ins, 1'b1, exp_pc, exp_jump);
    accept(np);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; ic_valid = 1'b0; ic_instr = 32'h0;
    dc_valid = 1'b0; dc_nextpc = 32'h0; rob_flush = 1'b0; rob_flush_pc = 32'h0;
    rob_br_valid = 1'b0; rob_br_pc = 32'h0; rob_br_taken = 1'b0;
    repeat (3) tick();
    checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL rst_ic_req got %0b want 0", ic_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %0b want 0", if_valid); end
    checks++; if (ic_addr !== 32'h0) begin errors++; $display("FAIL rst_ic_addr got %h want 0", ic_addr); end
    checks++;
    if ({instr, pc, isjump} !== 65'h0) begin
      errors++; $display("FAIL rst_outputs got instr=%h pc=%h isjump=%0b want 0", instr, pc, isjump);
    end
    checks++; if (dbg_state_o !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", dbg_state_o, ST_IDLE); end
    rst_in = 1'b0;
    tick();
    checks++;
    if (ic_req !== 1'b1 || ic_addr !== 32'h0 || dbg_state_o !== ST_WAIT) begin
      errors++; $display("FAIL first_req got req=%0b addr=%h st=%0d want 1 0 %0d", ic_req, ic_addr, dbg_state_o, ST_WAIT);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      wait_req();
      checks++;
      if (ic_addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr got %h want %h", ic_addr, 32'(4 * k)); end
      tick();
      checks++;
      if (ic_req !== 1'b1 || ic_addr !== 32'(4 * k)) begin
        errors++; $display("FAIL seq_hold_req got req=%0b addr=%h want 1 %h", ic_req, ic_addr, 32'(4 * k));
      end
      respond(NOP, 1'b1, 32'(4 * k), 1'b0);
      checks++;
      if (if_valid !== 1'b1 || ic_req !== 1'b0) begin
        errors++; $display("FAIL seq_if_valid got if_valid=%0b req=%0b want 1 0", if_valid, ic_req);
      end
      accept(32'(4 * k + 4));
      checks++;
      if (if_valid !== 1'b0 || ic_req !== 1'b0) begin
        errors++; $display("FAIL seq_accept got if_valid=%0b req=%0b want 0 0", if_valid, ic_req);
      end
      tick();
      checks++;
      if (ic_req !== 1'b1) begin errors++; $display("FAIL seq_req_latency got %0b want 1", ic_req); end
    end
  endtask

  task automatic test_bht();
    train(32'h10, 1'b1, 3);
    fetch(32'h0c, NOP, 1'b0, 32'h10);
    fetch(32'h10, BEQ, 1'b1, 32'h10);
    fetch(32'h10, NOP, 1'b0, 32'h10);
    train(32'h10, 1'b0, 2);
    fetch(32'h10, BEQ, 1'b0, 32'h10);
    train(32'h10, 1'b0, 3);
    train(32'h10, 1'b1, 2);
    fetch(32'h10, BEQ, 1'b1, 32'h10);
    train(32'h10, 1'b0, 1);
    wait_req();
    rob_br_valid = 1'b1; rob_br_pc = 32'h10; rob_br_taken = 1'b1;
    respond(BEQ, 1'b1, 32'h10, 1'b0);
    rob_br_valid = 1'b0;
    accept(32'h10);
    fetch(32'h10, BEQ, 1'b1, 32'h20);
  endtask

  task automatic test_flush_wait();
    wait_req();
    checks++;
    if (ic_addr !== 32'h20) begin errors++; $display("FAIL fw_addr got %h want 20", ic_addr); end
    rob_flush = 1'b1; rob_flush_pc = 32'h100;
    tick();
    rob_flush = 1'b0;
    checks++;
    if (dbg_state_o !== ST_DISCARD || ic_req !== 1'b1 || ic_addr !== 32'h20) begin
      errors++; $display("FAIL fw_discard got st=%0d req=%0b addr=%h want %0d 1 20", dbg_state_o, ic_req, ic_addr, ST_DISCARD);
    end
    tick();
    respond(32'h12345678, 1'b0, 32'h0, 1'b0);
    checks++;
    if (if_valid !== 1'b0 || ic_req !== 1'b0) begin
      errors++; $display("FAIL fw_drop got if_valid=%0b req=%0b want 0 0", if_valid, ic_req);
    end
    wait_req();
    checks++;
    if (ic_addr !== 32'h100) begin errors++; $display("FAIL fw_redirect got %h want 100", ic_addr); end
    respond(NOP, 1'b1, 32'h100, 1'b0);
    respond(32'hdeadbeef, 1'b0, 32'h0, 1'b0);
    checks++;
    if (if_valid !== 1'b1 || instr !== NOP) begin
      errors++; $display("FAIL hold_ignore_icv got if_valid=%0b instr=%h want 1 %h", if_valid, instr, NOP);
    end
  endtask

  task automatic test_flush_hold();
    dc_valid = 1'b1; dc_nextpc = 32'h44;
    rob_flush = 1'b1; rob_flush_pc = 32'h200;
    tick();
    dc_valid = 1'b0; rob_flush = 1'b0;
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL fh_if_valid got %0b want 0", if_valid); end
    wait_req();
    checks++;
    if (ic_addr !== 32'h200) begin errors++; $display("FAIL fh_addr got %h want 200", ic_addr); end
  endtask

  task automatic test_rdy();
    rdy_in = 1'b0;
    rob_br_valid = 1'b1; rob_br_pc = 32'h200; rob_br_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ic_valid = (i == 2);
      ic_instr = BEQ;
      tick();
      ic_valid = 1'b0;
      checks++;
      if (ic_req !== 1'b1 || if_valid !== 1'b0 || dbg_state_o !== ST_WAIT || ic_addr !== 32'h200) begin
        errors++; $display("FAIL rdy_hold got req=%0b if_valid=%0b st=%0d addr=%h want 1 0 %0d 200",
                           ic_req, if_valid, dbg_state_o, ic_addr, ST_WAIT);
      end
    end
    rob_br_valid = 1'b0;
    rdy_in = 1'b1;
    respond(BEQ, 1'b1, 32'h200, 1'b0);
  endtask

  task automatic test_reset_hold();
    accept(32'h0);
    train(32'h0, 1'b1, 2);
    wait_req();
    respond(BEQ, 1'b1, 32'h0, 1'b1);
    rst_in = 1'b1;
    tick();
    checks++;
    if (if_valid !== 1'b0 || ic_req !== 1'b0) begin
      errors++; $display("FAIL rh_outputs got if_valid=%0b req=%0b want 0 0", if_valid, ic_req);
    end
    rst_in = 1'b0;
    tick();
    checks++;
    if (ic_req !== 1'b1 || ic_addr !== 32'h0) begin
      errors++; $display("FAIL rh_addr got req=%0b addr=%h want 1 0", ic_req, ic_addr);
    end
    respond(BEQ, 1'b1, 32'h0, 1'b0);
    accept(32'h4);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_bht();
    test_flush_wait();
    test_flush_hold();
    test_rdy();
    test_reset_hold();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
